alu_param: RTL

Parametrised successor to the 16-bit ALU top. It is a WIDTH-bit ALU with a start/busy/done handshake covering:
- single-cycle add/sub, logic and barrel-shift/rotate operations;
- a sequential radix-2 Booth signed multiplier with a 2·WIDTH-bit MH:ML result;
- an optional sequential unsigned divider.

It sits in the datapath exactly where the fixed-width ALU does: operands come from the general registers and results go to AR, MH:ML and the status nibble.

---
 rtl/alu_param.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_param.sv
// alu_param: WIDTH-bit ALU with start/busy/done handshake, Booth multiplier
// and an optional restoring divider built only when ALU_DIV_EN is defined.
module alu_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     opx,
    input  logic [WIDTH-1:0]     opy,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     ar,
    output logic [2*WIDTH-1:0]   mult_out,
    output logic [3:0]           sta
);
    localparam int SH = $clog2(WIDTH);
    localparam logic [SH:0] LAST = (SH+1)'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADC = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_SAR = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam logic [3:0] OP_CMP = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

    state_t           state, state_nx;
    logic [SH:0]      cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic             last;
    logic             is_mul;
    logic             is_seq;

    assign last   = (cnt == LAST);
    assign is_mul = (opcode == OP_MUL);

    // Single-cycle datapath
    logic [SH-1:0]    amt;
    logic [WIDTH:0]   add_s, sub_d, shl_w, shr_w, sar_w;
    logic [WIDTH-1:0] rol_r, res;
    logic             c_f, v_f, wr_ar, wr_sta;
    logic [3:0]       flags;

    assign amt   = opy[SH-1:0];
    assign add_s = {1'b0, opx} + {1'b0, opy}
                 + (WIDTH+1)'(cin & (opcode == OP_ADC));
    assign sub_d = {1'b0, opx} - {1'b0, opy}
                 - (WIDTH+1)'(cin & (opcode == OP_SBB));
    assign shl_w = {1'b0, opx} << amt;
    assign shr_w = {opx, 1'b0} >> amt;
    assign sar_w = (WIDTH+1)'($signed({opx, 1'b0}) >>> amt);
    assign rol_r = (opx << amt)
                 | (opx >> ((SH+1)'(WIDTH) - {1'b0, amt}));

    always_comb begin
        res    = '0;
        c_f    = 1'b0;
        v_f    = 1'b0;
        wr_ar  = 1'b0;
        wr_sta = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                res    = add_s[WIDTH-1:0];
                c_f    = add_s[WIDTH];
                v_f    = (opx[WIDTH-1] == opy[WIDTH-1])
                       && (res[WIDTH-1] != opx[WIDTH-1]);
                wr_ar  = 1'b1;
                wr_sta = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                res    = sub_d[WIDTH-1:0];
                c_f    = sub_d[WIDTH];
                v_f    = (opx[WIDTH-1] != opy[WIDTH-1])
                       && (res[WIDTH-1] != opx[WIDTH-1]);
                wr_ar  = (opcode != OP_CMP);
                wr_sta = 1'b1;
            end
            OP_AND: begin res = opx & opy; wr_ar = 1'b1; wr_sta = 1'b1; end
            OP_OR:  begin res = opx | opy; wr_ar = 1'b1; wr_sta = 1'b1; end
            OP_XOR: begin res = opx ^ opy; wr_ar = 1'b1; wr_sta = 1'b1; end
            OP_NOT: begin res = ~opx;      wr_ar = 1'b1; wr_sta = 1'b1; end
            OP_SHL: begin
                {c_f, res} = shl_w;
                wr_ar      = 1'b1;
                wr_sta     = 1'b1;
            end
            OP_SHR: begin
                {res, c_f} = shr_w;
                wr_ar      = 1'b1;
                wr_sta     = 1'b1;
            end
            OP_SAR: begin
                {res, c_f} = sar_w;
                wr_ar      = 1'b1;
                wr_sta     = 1'b1;
            end
            OP_ROL: begin
                res    = rol_r;
                c_f    = (amt != '0) & rol_r[0];
                wr_ar  = 1'b1;
                wr_sta = 1'b1;
            end
            default: ;
        endcase
        flags = {v_f, c_f, res[WIDTH-1], res == '0};
    end

    // Booth step: add/sub M by {Q[0],q-1}, then arithmetic shift {A,Q,q-1}
    logic [WIDTH:0]     b_sum, b_acc;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] prod;
    logic               mul_fit;
    logic [3:0]         mul_sta;

    always_comb begin
        b_sum = acc;
        if (q[0] & ~qm1)
            b_sum = acc - m;
        else if (~q[0] & qm1)
            b_sum = acc + m;
        b_acc = {b_sum[WIDTH], b_sum[WIDTH:1]};
        b_q   = {b_sum[0], q[WIDTH-1:1]};
    end

    assign prod    = {b_acc[WIDTH-1:0], b_q};
    assign mul_fit = (&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]);
    assign mul_sta = {~mul_fit, ~mul_fit, prod[2*WIDTH-1], prod == '0};

`ifdef ALU_DIV_EN
    // Restoring step; a zero divisor never restores, leaving Q=~0 and R=x
    logic               is_div;
    logic               dz;
    logic [WIDTH:0]     d_rs, d_acc;
    logic [WIDTH+1:0]   d_tr;
    logic [WIDTH-1:0]   d_q;
    logic [2*WIDTH-1:0] quo_rem;
    logic [3:0]         div_sta;

    assign is_div = (opcode == OP_DIV);
    assign is_seq = is_mul | is_div;

    always_comb begin
        d_rs = {acc[WIDTH-1:0], q[WIDTH-1]};
        d_tr = {1'b0, d_rs} - {1'b0, m};
        if (d_tr[WIDTH+1]) begin
            d_acc = d_rs;
            d_q   = {q[WIDTH-2:0], 1'b0};
        end else begin
            d_acc = d_tr[WIDTH:0];
            d_q   = {q[WIDTH-2:0], 1'b1};
        end
    end

    assign quo_rem = {d_acc[WIDTH-1:0], d_q};
    assign div_sta = {dz, 1'b0, 1'b0, d_q == '0};
`else
    assign is_seq = is_mul;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && is_mul)
                    state_nx = RUN_MUL;
`ifdef ALU_DIV_EN
                else if (start && is_div)
                    state_nx = RUN_DIV;
`endif
            end
            RUN_MUL, RUN_DIV: if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar       <= '0;
            mult_out <= '0;
            sta      <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            qm1      <= 1'b0;
`ifdef ALU_DIV_EN
            dz       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    cnt <= '0;
                    acc <= '0;
                    q   <= opx;
                    qm1 <= 1'b0;
                    m   <= {opy[WIDTH-1], opy};
`ifdef ALU_DIV_EN
                    dz  <= (opy == '0);
                    if (is_div)
                        m <= {1'b0, opy};
`endif
                    if (!is_seq) begin
                        if (wr_ar)
                            ar <= res;
                        if (wr_sta)
                            sta <= flags;
                        done <= 1'b1;
                    end
                end
                RUN_MUL: begin
                    acc <= b_acc;
                    q   <= b_q;
                    qm1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        mult_out <= prod;
                        sta      <= mul_sta;
                        done     <= 1'b1;
                        cnt      <= '0;
                    end
                end
`ifdef ALU_DIV_EN
                RUN_DIV: begin
                    acc <= d_acc;
                    q   <= d_q;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        mult_out <= quo_rem;
                        sta      <= div_sta;
                        done     <= 1'b1;
                        cnt      <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
